// File: rtl/servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_decoder
// Description : Measures the high time of one servo PWM line in 10 us ticks
//               and decodes it back to the 3-bit angle code (1..5). Flags
//               out-of-window pulses, overlong pulses and loss of signal.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_decoder #(
  parameter int TICK_CYCLES = 500,
  parameter int TOL         = 10,
  parameter int MAX_W       = 300,
  parameter int TIMEOUT     = 2500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [2:0] angle_code,
  output logic [8:0] width,
  output logic       valid,
  output logic       range_err,
  output logic       overlong,
  output logic       signal_lost
);

  localparam int c_PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int c_TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_CYCLES - 1);
  localparam logic [c_TO_W-1:0]  c_TO_MAX   = c_TO_W'(TIMEOUT);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT - 1);
  localparam logic [8:0]         c_MAX_W    = 9'(MAX_W);
  localparam logic [8:0]         c_OVER_W   = 9'(MAX_W + 1);
  localparam logic [8:0]         c_CNT_SAT  = 9'h1FF;

  typedef enum logic [1:0] {
    S_SYNC     = 2'd0,
    S_ARMED    = 2'd1,
    S_HIGH     = 2'd2,
    S_CLASSIFY = 2'd3
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               r_prev;
  logic               r_rise;
  logic               r_fall;
  logic [1:0]         r_fill;
  logic [c_PRE_W-1:0] r_pre;
  logic [c_TO_W-1:0]  r_to;
  logic [8:0]         r_cnt;
  state_t             r_state;

  logic               w_tick;
  logic               w_primed;
  logic [8:0]         w_cnt_next;
  logic               w_over;
  logic               w_to_hit;
  logic [2:0]         w_code;

  // The edge flags are held off until the synchronizer chain holds real
  // samples, so a line that is already high at reset release never looks
  // like a fresh rising edge.
  assign w_primed = (r_fill == 2'd3);

  // Synchronize the asynchronous input and register one-cycle edge flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_fill  <= 2'd0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_primed) begin
        r_fill <= r_fill + 2'd1;
      end
      r_rise  <= w_primed & r_sync2 & ~r_prev;
      r_fall  <= w_primed & ~r_sync2 & r_prev;
    end
  end

  assign w_tick = (r_pre == c_PRE_LAST);

  // Free-running 10 us prescaler, realigned to every detected rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre <= '0;
    end else if (r_rise || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Width counter advances on ticks and saturates at the top of its range.
  assign w_cnt_next = (w_tick && (r_cnt != c_CNT_SAT)) ? (r_cnt + 9'd1) : r_cnt;
  assign w_over     = (w_cnt_next > c_MAX_W);

  // A rise in the same cycle as the timeout wins, so the loss is not flagged.
  assign w_to_hit = w_tick && (r_to == c_TO_LAST) && (r_state != S_HIGH) &&
                    !((r_state == S_ARMED) && r_rise);

  // Map the measured width to the code whose tolerance window contains it.
  always_comb begin
    w_code = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      if (({1'b0, r_cnt} >= 10'(50 * k - TOL)) &&
          ({1'b0, r_cnt} <= 10'(50 * k + TOL))) begin
        w_code = 3'(k);
      end
    end
  end

  // Decoder state machine, timeout supervision and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_SYNC;
      r_cnt       <= 9'd0;
      r_to        <= '0;
      angle_code  <= 3'd0;
      width       <= 9'd0;
      valid       <= 1'b0;
      range_err   <= 1'b0;
      overlong    <= 1'b0;
      signal_lost <= 1'b0;
    end else begin
      valid     <= 1'b0;
      range_err <= 1'b0;
      overlong  <= 1'b0;

      // Timeout only runs while no pulse is being measured.
      if ((r_state != S_HIGH) && w_tick && (r_to != c_TO_MAX)) begin
        r_to <= r_to + 1'b1;
      end
      if (w_to_hit) begin
        signal_lost <= 1'b1;
        angle_code  <= 3'd0;
      end

      case (r_state)
        S_SYNC: begin
          // Wait for a genuine low so a pulse already in progress is dropped.
          if (w_primed && !r_prev) begin
            r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          r_cnt <= 9'd0;
          if (r_rise) begin
            r_state     <= S_HIGH;
            r_to        <= '0;
            signal_lost <= 1'b0;
          end
        end
        S_HIGH: begin
          r_cnt <= w_cnt_next;
          if (w_over) begin
            overlong   <= 1'b1;
            angle_code <= 3'd0;
            width      <= c_OVER_W;
            r_state    <= S_SYNC;
          end else if (r_fall) begin
            r_state <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          width      <= r_cnt;
          angle_code <= w_code;
          range_err  <= (w_code == 3'd0);
          valid      <= 1'b1;
          r_state    <= S_ARMED;
        end
        default: begin
          r_state <= S_SYNC;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_pwm_decoder
// Description : Self-checking bench for servo_pwm_decoder. A pulse-level model
//               predicts every output on every cycle; directed pulses also
//               carry hand-computed expected codes and widths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_decoder;

  localparam int TK    = 4;
  localparam int TOL   = 10;
  localparam int MAX_W = 300;
  localparam int TO    = 2500;

  localparam int K_VALID = 0;
  localparam int K_OVER  = 1;
  localparam int K_LOST  = 2;
  localparam int K_CLR   = 3;

  typedef struct {
    int e;
    int kind;
    int code;
    int w;
    int rerr;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic [2:0] angle_code;
  logic [8:0] width;
  logic       valid;
  logic       range_err;
  logic       overlong;
  logic       signal_lost;

  int  ecnt = 0;
  int  n_checks = 0;
  int  n_err = 0;
  int  n_valid = 0;
  int  n_over = 0;
  int  cap_rerr = 0;

  ev_t evq[$];
  ev_t cur_ev;
  bit  armed = 1'b0;
  bit  lost_pending = 1'b0;
  int  lost_edge = 0;

  logic [2:0] exp_code = 3'd0;
  logic [8:0] exp_w = 9'd0;
  logic       exp_valid = 1'b0;
  logic       exp_rerr = 1'b0;
  logic       exp_over = 1'b0;
  logic       exp_lost = 1'b0;

  servo_pwm_decoder #(
    .TICK_CYCLES(TK),
    .TOL        (TOL),
    .MAX_W      (MAX_W),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .angle_code (angle_code),
    .width      (width),
    .valid      (valid),
    .range_err  (range_err),
    .overlong   (overlong),
    .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Code whose nominal width 50*k lies within TOL ticks, else 0.
  function automatic int decode(input int w);
    int c;
    c = 0;
    for (int k = 1; k <= 5; k++) begin
      if (w >= 50 * k - TOL && w <= 50 * k + TOL) c = k;
    end
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ev(input int e, input int kind, input int code, input int w, input int rerr);
    ev_t ev;
    ev.e = e; ev.kind = kind; ev.code = code; ev.w = w; ev.rerr = rerr;
    evq.push_back(ev);
  endtask

  // Predict the decoder's reaction to a high pulse starting now.
  // Edges are numbered by posedge count; the rise is sampled at r and acts
  // three edges later, ticks fall every TK edges after that.
  task automatic sched(input int hi);
    int r;
    int w;
    r = ecnt + 1;
    w = hi / TK;
    if (armed) begin
      if (lost_pending && lost_edge < r + 3) push_ev(lost_edge, K_LOST, 0, 0, 0);
      push_ev(r + 3, K_CLR, 0, 0, 0);
      if (w > MAX_W) begin
        push_ev(r + 3 + (MAX_W + 1) * TK, K_OVER, 0, MAX_W + 1, 0);
        w = MAX_W + 1;
        armed = 1'b0;
      end else begin
        push_ev(r + hi + 4, K_VALID, decode(w), w, (decode(w) == 0) ? 1 : 0);
      end
      lost_pending = 1'b1;
      lost_edge = r + 3 + (w + TO) * TK;
    end
  endtask

  task automatic drive(input bit lvl, input int n);
    pwm_in = lvl;
    if (!lvl) armed = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo, input int e_code, input int e_w, input int e_rerr);
    int v0;
    v0 = n_valid;
    sched(hi);
    drive(1'b1, hi);
    drive(1'b0, lo);
    chk("pulse_valid_count", n_valid - v0, 1);
    chk("pulse_angle_code", int'(angle_code), e_code);
    chk("pulse_width", int'(width), e_w);
    chk("pulse_range_err", cap_rerr, e_rerr);
    chk("pulse_signal_lost", int'(signal_lost), 0);
  endtask

  // Strobe capture for the directed checks.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      cap_rerr = int'(range_err);
    end
    if (overlong) n_over++;
  end

  // Cycle-by-cycle comparison against the pulse-level model.
  always @(negedge clk) begin
    exp_valid = 1'b0;
    exp_rerr  = 1'b0;
    exp_over  = 1'b0;
    while (evq.size() > 0 && evq[0].e <= ecnt) begin
      cur_ev = evq.pop_front();
      case (cur_ev.kind)
        K_VALID: begin
          exp_valid = 1'b1;
          exp_rerr  = (cur_ev.rerr != 0);
          exp_code  = 3'(cur_ev.code);
          exp_w     = 9'(cur_ev.w);
        end
        K_OVER: begin
          exp_over = 1'b1;
          exp_code = 3'd0;
          exp_w    = 9'(cur_ev.w);
        end
        K_LOST: begin
          exp_lost = 1'b1;
          exp_code = 3'd0;
        end
        default: exp_lost = 1'b0;
      endcase
    end
    if (lost_pending && ecnt == lost_edge) begin
      exp_lost = 1'b1;
      exp_code = 3'd0;
      lost_pending = 1'b0;
    end
    n_checks++;
    if ({angle_code, width, valid, range_err, overlong, signal_lost} !==
        {exp_code, exp_w, exp_valid, exp_rerr, exp_over, exp_lost}) begin
      n_err++;
      $display("FAIL model_cmp edge %0d: got code=%0d width=%0d valid=%0b rerr=%0b over=%0b lost=%0b, expected code=%0d width=%0d valid=%0b rerr=%0b over=%0b lost=%0b",
               ecnt, angle_code, width, valid, range_err, overlong, signal_lost,
               exp_code, exp_w, exp_valid, exp_rerr, exp_over, exp_lost);
    end
  end

  initial begin
    int v0;
    int o0;
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_angle_code", int'(angle_code), 0);
    chk("reset_width", int'(width), 0);
    chk("reset_signal_lost", int'(signal_lost), 0);
    reset = 1'b0;
    lost_pending = 1'b1;
    lost_edge = ecnt + TO * TK;
    drive(1'b0, 20);

    // Three 20 ms frames at 1.5 ms.
    for (int i = 0; i < 3; i++) pulse(150 * TK + 1, 1850 * TK - 1, 3, 150, 0);

    // Sweep of nominal positions and tolerance boundaries.
    pulse(50 * TK + 1, 200, 1, 50, 0);
    pulse(100 * TK + 3, 200, 2, 100, 0);
    pulse(200 * TK + 1, 200, 4, 200, 0);
    pulse(250 * TK + 2, 200, 5, 250, 0);
    pulse(60 * TK, 200, 1, 60, 0);
    pulse(61 * TK, 200, 0, 61, 1);
    pulse(40 * TK, 200, 1, 40, 0);
    pulse(39 * TK + 3, 200, 0, 39, 1);
    pulse(125 * TK, 200, 0, 125, 1);
    pulse(3, 200, 0, 0, 1);

    // Line stuck high for 4 ms, then a normal 1.0 ms pulse.
    v0 = n_valid;
    o0 = n_over;
    sched(400 * TK);
    drive(1'b1, 400 * TK);
    drive(1'b0, 200);
    chk("ovl_count", n_over - o0, 1);
    chk("ovl_no_valid", n_valid - v0, 0);
    chk("ovl_width", int'(width), 301);
    chk("ovl_angle_code", int'(angle_code), 0);
    pulse(100 * TK + 1, 200, 2, 100, 0);

    // Code-3 frame followed by 30 ms of silence, then a 2.0 ms pulse.
    sched(150 * TK + 1);
    drive(1'b1, 150 * TK + 1);
    drive(1'b0, 50);
    chk("pre_loss_angle_code", int'(angle_code), 3);
    drive(1'b0, 3000 * TK - 50);
    chk("loss_signal_lost", int'(signal_lost), 1);
    chk("loss_angle_code", int'(angle_code), 0);
    sched(200 * TK + 1);
    drive(1'b1, 6);
    chk("loss_clear_at_rise", int'(signal_lost), 0);
    drive(1'b1, 200 * TK + 1 - 6);
    drive(1'b0, 200);
    chk("recover_angle_code", int'(angle_code), 4);
    chk("recover_width", int'(width), 200);

    // Reset asserted mid-pulse and released while the line is still high.
    v0 = n_valid;
    sched(150 * TK + 1);
    drive(1'b1, 300);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_angle_code", int'(angle_code), 0);
    chk("midrst_width", int'(width), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_range_err", int'(range_err), 0);
    chk("midrst_overlong", int'(overlong), 0);
    chk("midrst_signal_lost", int'(signal_lost), 0);
    evq.delete();
    exp_code = 3'd0;
    exp_w    = 9'd0;
    exp_lost = 1'b0;
    armed = 1'b0;
    lost_pending = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b0;
    lost_pending = 1'b1;
    lost_edge = ecnt + TO * TK;
    drive(1'b1, 280);
    drive(1'b0, 200);
    chk("partial_no_valid", n_valid - v0, 0);
    chk("partial_angle_code", int'(angle_code), 0);
    pulse(150 * TK + 1, 200, 3, 150, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
